// File: rtl/bus_interconnect_if.sv
// bus_interconnect_if: master-side and slave-side signal bundle of the interconnect
interface bus_interconnect_if #(
  parameter int NSLAVES = 4,
  parameter int AW = 30,
  parameter int DW = 32
);
  logic m_cyc;
  logic m_we;
  logic [AW-1:0] m_addr;
  logic [DW/8-1:0] m_sel;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic m_ack;
  logic m_err;
  logic s_cyc;
  logic [NSLAVES-1:0] s_stb;
  logic s_we;
  logic [AW-1:0] s_addr;
  logic [DW/8-1:0] s_sel;
  logic [DW-1:0] s_wdata;
  logic [NSLAVES*DW-1:0] s_rdata;
  logic [NSLAVES-1:0] s_ack;
  modport master (
    output m_cyc, m_we, m_addr, m_sel, m_wdata, s_rdata, s_ack,
    input m_rdata, m_ack, m_err, s_cyc, s_stb, s_we, s_addr, s_sel, s_wdata
  );
  modport slave (
    input m_cyc, m_we, m_addr, m_sel, m_wdata, s_rdata, s_ack,
    output m_rdata, m_ack, m_err, s_cyc, s_stb, s_we, s_addr, s_sel, s_wdata
  );
endinterface

// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master N-slave cyc/stb/ack interconnect with windowed decode; define BUS_TIMEOUT_EN for the ack timeout
module bus_interconnect #(
  parameter int NSLAVES = 4,
  parameter int AW = 30,
  parameter int DW = 32,
  parameter logic [32*NSLAVES-1:0] SLAVE_BASE = {32'h800, 32'h408, 32'h404, 32'h400},
  parameter logic [32*NSLAVES-1:0] SLAVE_SIZE = {32'h400, 32'h4, 32'h4, 32'h4},
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  bus_interconnect_if.slave bus
);
  localparam int IW = NSLAVES > 1 ? $clog2(NSLAVES) : 1;
  localparam int CW = AW + 3 > 33 ? AW + 3 : 33;
  typedef enum logic [1:0] {IDLE, BUSY, RESP, RECOVER} state_t;
  state_t state_q, state_d;
  logic hit;
  logic [IW-1:0] hit_idx, idx_q;
  logic ack_sel, to, err_q;
  logic [DW-1:0] rdata_q, s_wdata_q;
  logic s_we_q;
  logic [AW-1:0] s_addr_q;
  logic [DW/8-1:0] s_sel_q;
  logic [CW-1:0] byte_addr;
  assign byte_addr = CW'({bus.m_addr, 2'b00});
  assign ack_sel = bus.s_ack[idx_q];
  assign bus.m_rdata = rdata_q;
  assign bus.s_we = s_we_q;
  assign bus.s_addr = s_addr_q;
  assign bus.s_sel = s_sel_q;
  assign bus.s_wdata = s_wdata_q;
  // lowest-index window containing the byte address wins; wide compare keeps base+size from wrapping
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (byte_addr >= CW'(SLAVE_BASE[32*i +: 32]) &&
          byte_addr < CW'(SLAVE_BASE[32*i +: 32]) + CW'(SLAVE_SIZE[32*i +: 32])) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end
`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt;
  // count BUSY cycles; held at zero outside BUSY so every transaction starts fresh
  always_ff @(posedge clk) cnt <= rst || state_q != BUSY ? '0 : cnt + 16'd1;
  assign to = state_q == BUSY && cnt == 16'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign to = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: ack beats abort beats timeout; RECOVER keeps a held m_cyc from re-issuing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.m_cyc ? (hit ? BUSY : RESP) : IDLE;
      BUSY: state_d = ack_sel ? RESP : !bus.m_cyc ? IDLE : to ? RESP : BUSY;
      RESP: state_d = RECOVER;
      default: state_d = IDLE;
    endcase
  end
  // state-decoded handshake outputs
  always_comb begin
    bus.s_cyc = state_q == BUSY;
    bus.s_stb = state_q == BUSY ? NSLAVES'(1) << idx_q : '0;
    bus.m_ack = state_q == RESP;
    bus.m_err = state_q == RESP && err_q;
  end
  // capture the request when leaving IDLE and the response when entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      s_we_q <= 1'b0;
      s_addr_q <= '0;
      s_sel_q <= '0;
      s_wdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.m_cyc) begin
        idx_q <= hit_idx;
        s_we_q <= bus.m_we;
        s_addr_q <= bus.m_addr;
        s_sel_q <= bus.m_sel;
        s_wdata_q <= bus.m_wdata;
      end
      if (state_d == RESP) begin
        err_q <= !(state_q == BUSY && ack_sel);
        rdata_q <= state_q == BUSY && ack_sel && !s_we_q ? bus.s_rdata[DW*idx_q +: DW] : '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: directed stimulus with a response scoreboard for bus_interconnect
module tb_bus_interconnect;
  localparam int NS = 4, AW = 30, DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  logic [DW:0] exp_q[$];
  always #5 clk = ~clk;
  bus_interconnect_if #(.NSLAVES(NS), .AW(AW), .DW(DW)) bus ();
  bus_interconnect #(.NSLAVES(NS), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  // scoreboard monitor: every m_ack must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && bus.m_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got m_ack=1 err=%0b rdata=%h, required no ack", bus.m_err, bus.m_rdata);
      end else begin
        if ({bus.m_err, bus.m_rdata} !== exp_q[0]) begin
          errors++;
          $display("FAIL response: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   bus.m_err, bus.m_rdata, exp_q[0][DW], exp_q[0][DW-1:0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic we, input logic [AW-1:0] a, input logic [3:0] sel, input logic [DW-1:0] d);
    bus.m_cyc = 1'b1;
    bus.m_we = we;
    bus.m_addr = a;
    bus.m_sel = sel;
    bus.m_wdata = d;
  endtask
  task automatic drop;
    bus.m_cyc = 1'b0;
    bus.m_we = 1'b0;
  endtask
  initial begin
    bus.m_cyc = 0; bus.m_we = 0; bus.m_addr = '0; bus.m_sel = '0; bus.m_wdata = '0;
    bus.s_rdata = '0; bus.s_ack = '0;
    repeat (2) tick;
    @(negedge clk);
    chk("reset_m_outputs", {bus.m_ack, bus.m_err, bus.m_rdata}, 0);
    chk("reset_s_ctrl", {bus.s_cyc, bus.s_stb, bus.s_we, bus.s_sel}, 0);
    chk("reset_s_data", {bus.s_addr, bus.s_wdata}, 0);
    tick;
    rst = 1'b0;
    tick;
    // read RAM, slave 3 acks the cycle after stb
    bus.s_rdata[DW*3 +: DW] = 32'hDEADBEEF;
    bus.s_rdata[DW*1 +: DW] = 32'h11111111;
    req(0, 30'h200, 4'h3, 32'h0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clk); chk("ram_c0_stb", bus.s_stb, 4'b0000);
    tick;
    @(negedge clk); chk("ram_c1_stb", bus.s_stb, 4'b1000);
    chk("ram_c1_shared", {bus.s_cyc, bus.s_we, bus.s_sel, bus.s_addr}, {1'b1, 1'b0, 4'h3, 30'h200});
    tick; bus.s_ack = 4'b1000;
    @(negedge clk); chk("ram_c2_noack", bus.m_ack, 0);
    tick; bus.s_ack = 4'b0000; drop;
    @(negedge clk); chk("ram_c3_ack", {bus.m_ack, bus.m_err, bus.m_rdata}, {2'b10, 32'hDEADBEEF});
    chk("ram_c3_stb_low", bus.s_stb, 0);
    tick;
    @(negedge clk); chk("ram_c4_recover", bus.m_ack, 0);
    tick;
    // unmapped address: immediate error, no strobe
    req(0, 30'h0, 4'hF, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk); chk("unmap_c0_stb", bus.s_stb, 0);
    tick;
    @(negedge clk); chk("unmap_c1_ack", {bus.m_ack, bus.m_err, bus.s_stb, bus.s_cyc}, {2'b11, 4'b0000, 1'b0});
    drop;
    repeat (2) tick;
    // LED write, combinational ack, read data must be 0
    bus.s_rdata[DW*0 +: DW] = 32'h1234;
    req(1, 30'h100, 4'hF, 32'h3F);
    exp_q.push_back({1'b0, 32'h0});
    tick; bus.s_ack = 4'b0001;
    @(negedge clk); chk("led_stb", bus.s_stb, 4'b0001);
    chk("led_shared", {bus.s_we, bus.s_wdata, bus.s_sel}, {1'b1, 32'h3F, 4'hF});
    tick; bus.s_ack = 0; drop;
    @(negedge clk); chk("led_ack", {bus.m_ack, bus.m_err}, 2'b10);
    repeat (2) tick;
    // stray ack from slave 1 while slave 3 is selected, then the real ack
    bus.s_rdata[DW*3 +: DW] = 32'hCAFEF00D;
    req(0, 30'h200, 4'hF, 32'h0);
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    tick; bus.s_ack = 4'b0010;
    tick; bus.s_ack = 4'b1000;
    @(negedge clk); chk("stray_still_busy", {bus.m_ack, bus.s_stb}, {1'b0, 4'b1000});
    tick; bus.s_ack = 0; drop;
    repeat (2) tick;
    // abort: drop m_cyc during BUSY
    req(0, 30'h102, 4'hF, 32'h0);
    tick;
    @(negedge clk); chk("abort_stb", bus.s_stb, 4'b0100);
    drop;
    tick;
    @(negedge clk); chk("abort_idle", {bus.s_cyc, bus.s_stb, bus.m_ack}, 0);
    repeat (2) tick;
    // reset in BUSY clears everything, then a fresh read works
    req(1, 30'h200, 4'hC, 32'hAA55);
    tick;
    @(negedge clk); chk("rst_busy_stb", {bus.s_stb, bus.s_we}, {4'b1000, 1'b1});
    rst = 1'b1;
    tick; rst = 1'b0; drop;
    @(negedge clk);
    chk("rst_mid_m", {bus.m_ack, bus.m_err, bus.m_rdata}, 0);
    chk("rst_mid_s", {bus.s_cyc, bus.s_stb, bus.s_we, bus.s_sel, bus.s_wdata}, 0);
    chk("rst_mid_addr", bus.s_addr, 0);
    tick;
    bus.s_rdata[DW*0 +: DW] = 32'h42;
    req(0, 30'h100, 4'hF, 32'h0);
    exp_q.push_back({1'b0, 32'h42});
    tick; bus.s_ack = 4'b0001;
    tick; bus.s_ack = 0; drop;
    @(negedge clk); chk("post_rst_read", {bus.m_ack, bus.m_rdata}, {1'b1, 32'h42});
    repeat (2) tick;
`ifdef BUS_TIMEOUT_EN
    // timeout: ack never comes, error 8 cycles after s_stb rises
    req(0, 30'h101, 4'hF, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    tick;
    @(negedge clk); chk("to_stb", bus.s_stb, 4'b0010);
    repeat (7) tick;
    @(negedge clk); chk("to_c8", {bus.m_ack, bus.s_stb}, {1'b0, 4'b0010});
    tick; drop;
    @(negedge clk); chk("to_c9", {bus.m_ack, bus.m_err}, 2'b11);
    tick; bus.s_ack = 4'b0010;
    @(negedge clk); chk("to_c10", {bus.m_ack, bus.s_stb}, 0);
    tick;
    @(negedge clk); chk("to_late_ack", bus.m_ack, 0);
    tick; bus.s_ack = 0;
    tick;
    // ack on the timeout cycle wins
    bus.s_rdata[DW*1 +: DW] = 32'h5A5A;
    req(0, 30'h101, 4'hF, 32'h0);
    exp_q.push_back({1'b0, 32'h5A5A});
    repeat (7) tick;
    @(negedge clk); chk("tie_c7", bus.m_ack, 0);
    tick; bus.s_ack = 4'b0010;
    tick; bus.s_ack = 0; drop;
    @(negedge clk); chk("tie_c9", {bus.m_ack, bus.m_err, bus.m_rdata}, {2'b10, 32'h5A5A});
    repeat (2) tick;
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
